// File: rtl/fall_alarm_controller.sv
// fall_alarm_controller: confirms a fall after CONFIRM_CYCLES consecutive
// high samples of fallDetected, latches the alarm until acknowledged, then
// waits COOLDOWN_CYCLES cycles before it can re-arm.
// Optional macro FALL_EVENT_COUNTER_EN adds a saturating 8-bit alarm-entry
// counter output (fallCount).
module fall_alarm_controller #(
  parameter int CONFIRM_CYCLES  = 4,
  parameter int COOLDOWN_CYCLES = 8,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fallDetected,
  input  logic       alarmAck,
  output logic       alarmOn,
  output logic       alarmPulse,
  output logic [1:0] state
`ifdef FALL_EVENT_COUNTER_EN
  ,
  output logic [7:0] fallCount
`endif
);

  localparam int MAX_CYC = (CONFIRM_CYCLES > COOLDOWN_CYCLES) ? CONFIRM_CYCLES : COOLDOWN_CYCLES;

  // Reject illegal configurations at elaboration.
  if (CONFIRM_CYCLES < 1 || CONFIRM_CYCLES > 255) begin : g_bad_confirm
    $error("CONFIRM_CYCLES must be in 1..255");
  end
  if (COOLDOWN_CYCLES < 1 || COOLDOWN_CYCLES > 255) begin : g_bad_cooldown
    $error("COOLDOWN_CYCLES must be in 1..255");
  end
  if ($clog2(MAX_CYC) > CNT_W) begin : g_bad_cntw
    $error("CNT_W too narrow for the configured cycle counts");
  end

  localparam logic [CNT_W-1:0] CONF_L     = CNT_W'(CONFIRM_CYCLES);
  localparam logic [CNT_W-1:0] COOL_LAST  = CNT_W'(COOLDOWN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_CONFIRM  = 2'b01,
    S_ALARM    = 2'b10,
    S_COOLDOWN = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             alarmOn_q, alarmOn_d;
  logic             alarmPulse_q, alarmPulse_d;

  assign cnt_inc = cnt_q + CNT_ONE;

  // Next-state, shared counter and registered-output precomputation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (fallDetected) begin
          if (CONFIRM_CYCLES == 1) begin
            state_d = S_ALARM;
            cnt_d   = '0;
          end else begin
            state_d = S_CONFIRM;
            cnt_d   = CNT_ONE;
          end
        end
      end
      S_CONFIRM: begin
        if (!fallDetected) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_inc == CONF_L) begin
          state_d = S_ALARM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_ALARM: begin
        if (alarmAck) begin
          state_d = S_COOLDOWN;
          cnt_d   = '0;
        end
      end
      S_COOLDOWN: begin
        if (cnt_q == COOL_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    alarmOn_d    = (state_d == S_ALARM);
    alarmPulse_d = (state_d == S_ALARM) && (state_q != S_ALARM);
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      alarmOn_q    <= 1'b0;
      alarmPulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alarmOn_q    <= alarmOn_d;
      alarmPulse_q <= alarmPulse_d;
    end
  end

  assign alarmOn    = alarmOn_q;
  assign alarmPulse = alarmPulse_q;
  assign state      = state_q;

`ifdef FALL_EVENT_COUNTER_EN
  logic [7:0] fallCount_q;

  // Saturating count of alarm entries, stepping with the alarmPulse rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      fallCount_q <= '0;
    end else if (alarmPulse_d && (fallCount_q != '1)) begin
      fallCount_q <= fallCount_q + 8'd1;
    end
  end

  assign fallCount = fallCount_q;
`endif

endmodule

// File: tb/tb_fall_alarm_controller.sv
// Directed self-checking bench for fall_alarm_controller (default 4/8 params);
// with FALL_EVENT_COUNTER_EN a second 1/1 instance exercises fallCount.
module tb_fall_alarm_controller;

  logic       clk;
  logic       rst;
  logic       fall;
  logic       ack;
  logic       alarmOn;
  logic       alarmPulse;
  logic [1:0] state;

  int checks;
  int errors;

  localparam logic [1:0] IDLE = 2'b00, CONF = 2'b01, ALRM = 2'b10, COOL = 2'b11;

`ifdef FALL_EVENT_COUNTER_EN
  logic [7:0] fc_main;
  logic       rst_c, fall_c, ack_c;
  logic       alarmOn_c, alarmPulse_c;
  logic [1:0] state_c;
  logic [7:0] fc_c;
`endif

  fall_alarm_controller #(
    .CONFIRM_CYCLES (4),
    .COOLDOWN_CYCLES(8),
    .CNT_W          (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fallDetected(fall),
    .alarmAck    (ack),
    .alarmOn     (alarmOn),
    .alarmPulse  (alarmPulse),
    .state       (state)
`ifdef FALL_EVENT_COUNTER_EN
    ,
    .fallCount   (fc_main)
`endif
  );

`ifdef FALL_EVENT_COUNTER_EN
  fall_alarm_controller #(
    .CONFIRM_CYCLES (1),
    .COOLDOWN_CYCLES(1),
    .CNT_W          (8)
  ) dut_c (
    .clk         (clk),
    .rst         (rst_c),
    .fallDetected(fall_c),
    .alarmAck    (ack_c),
    .alarmOn     (alarmOn_c),
    .alarmPulse  (alarmPulse_c),
    .state       (state_c),
    .fallCount   (fc_c)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; fall = 1'b0; ack = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; fall = 1'b1; ack = 1'b1;
    step();
    checks++;
    if (state !== IDLE || alarmOn !== 1'b0 || alarmPulse !== 1'b0) begin
      errors++;
      $display("FAIL reset: state=%b on=%b pulse=%b, want 00 0 0", state, alarmOn, alarmPulse);
    end
    rst = 1'b0; fall = 1'b0; ack = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    fall = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (state !== CONF || alarmOn !== 1'b0) begin
      errors++;
      $display("FAIL basic_3rd: state=%b on=%b, want 01 0", state, alarmOn);
    end
    step();
    checks++;
    if (state !== ALRM || alarmOn !== 1'b1 || alarmPulse !== 1'b1) begin
      errors++;
      $display("FAIL basic_4th: state=%b on=%b pulse=%b, want 10 1 1", state, alarmOn, alarmPulse);
    end
    step();
    checks++;
    if (state !== ALRM || alarmOn !== 1'b1 || alarmPulse !== 1'b0) begin
      errors++;
      $display("FAIL basic_hold: state=%b on=%b pulse=%b, want 10 1 0", state, alarmOn, alarmPulse);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    fall = 1'b1;
    for (int i = 0; i < 3; i++) step();
    fall = 1'b0;
    step();
    checks++;
    if (state !== IDLE || alarmOn !== 1'b0) begin
      errors++;
      $display("FAIL glitch_drop: state=%b on=%b, want 00 0", state, alarmOn);
    end
    fall = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (state !== CONF || alarmOn !== 1'b0) begin
      errors++;
      $display("FAIL glitch_3rd: state=%b on=%b, want 01 0", state, alarmOn);
    end
    step();
    checks++;
    if (state !== ALRM || alarmOn !== 1'b1 || alarmPulse !== 1'b1) begin
      errors++;
      $display("FAIL glitch_alarm: state=%b on=%b pulse=%b, want 10 1 1", state, alarmOn, alarmPulse);
    end
  endtask

  // Entered in ALARM with fall=1 held.
  task automatic test_cooldown();
    ack = 1'b1;
    step();
    ack = 1'b0;
    checks++;
    if (state !== COOL || alarmOn !== 1'b0 || alarmPulse !== 1'b0) begin
      errors++;
      $display("FAIL cool_entry: state=%b on=%b pulse=%b, want 11 0 0", state, alarmOn, alarmPulse);
    end
    for (int i = 0; i < 7; i++) begin
      step();
      checks++;
      if (state !== COOL) begin
        errors++;
        $display("FAIL cool_hold[%0d]: state=%b, want 11", i, state);
      end
    end
    step();
    checks++;
    if (state !== IDLE || alarmOn !== 1'b0) begin
      errors++;
      $display("FAIL cool_exit: state=%b on=%b, want 00 0", state, alarmOn);
    end
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (state !== CONF || alarmOn !== 1'b0) begin
      errors++;
      $display("FAIL rearm_3rd: state=%b on=%b, want 01 0", state, alarmOn);
    end
    step();
    checks++;
    if (state !== ALRM || alarmPulse !== 1'b1) begin
      errors++;
      $display("FAIL rearm_alarm: state=%b pulse=%b, want 10 1", state, alarmPulse);
    end
    fall = 1'b0;
  endtask

  task automatic test_ack_held();
    rst = 1'b1; fall = 1'b0; ack = 1'b1;
    step();
    rst = 1'b0;
    step();
    checks++;
    if (state !== IDLE) begin
      errors++;
      $display("FAIL ackheld_idle: state=%b, want 00", state);
    end
    fall = 1'b1;
    step();
    checks++;
    if (state !== CONF) begin
      errors++;
      $display("FAIL ackheld_confirm: state=%b, want 01", state);
    end
    step(); step();
    checks++;
    if (state !== CONF || alarmOn !== 1'b0) begin
      errors++;
      $display("FAIL ackheld_confirm3: state=%b on=%b, want 01 0", state, alarmOn);
    end
    step();
    checks++;
    if (state !== ALRM || alarmOn !== 1'b1 || alarmPulse !== 1'b1) begin
      errors++;
      $display("FAIL ackheld_alarm: state=%b on=%b pulse=%b, want 10 1 1", state, alarmOn, alarmPulse);
    end
    step();
    checks++;
    if (state !== COOL || alarmOn !== 1'b0 || alarmPulse !== 1'b0) begin
      errors++;
      $display("FAIL ackheld_1cyc: state=%b on=%b pulse=%b, want 11 0 0", state, alarmOn, alarmPulse);
    end
    fall = 1'b0; ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    fall = 1'b1;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (state !== ALRM) begin
      errors++;
      $display("FAIL midrst_setup: state=%b, want 10", state);
    end
    rst = 1'b1;
    step();
    checks++;
    if (state !== IDLE || alarmOn !== 1'b0 || alarmPulse !== 1'b0) begin
      errors++;
      $display("FAIL midrst_alarm: state=%b on=%b pulse=%b, want 00 0 0", state, alarmOn, alarmPulse);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (state !== COOL) begin
      errors++;
      $display("FAIL midrst_cool_setup: state=%b, want 11", state);
    end
    rst = 1'b1;
    step();
    checks++;
    if (state !== IDLE || alarmOn !== 1'b0 || alarmPulse !== 1'b0) begin
      errors++;
      $display("FAIL midrst_cool: state=%b on=%b pulse=%b, want 00 0 0", state, alarmOn, alarmPulse);
    end
    rst = 1'b0; fall = 1'b0;
    step();
    checks++;
    if (state !== IDLE) begin
      errors++;
      $display("FAIL midrst_after: state=%b, want 00", state);
    end
  endtask

`ifdef FALL_EVENT_COUNTER_EN
  task automatic test_fall_counter();
    rst_c = 1'b1; fall_c = 1'b0; ack_c = 1'b0;
    step();
    rst_c = 1'b0;
    checks++;
    if (fc_c !== 8'd0) begin
      errors++;
      $display("FAIL cnt_reset: fallCount=%0d, want 0", fc_c);
    end
    for (int i = 0; i < 3; i++) begin
      fall_c = 1'b1; ack_c = 1'b0;
      step();
      checks++;
      if (state_c !== ALRM || alarmPulse_c !== 1'b1 || fc_c !== 8'(i + 1)) begin
        errors++;
        $display("FAIL cnt_event[%0d]: state=%b pulse=%b fallCount=%0d, want 10 1 %0d",
                 i, state_c, alarmPulse_c, fc_c, i + 1);
      end
      fall_c = 1'b0; ack_c = 1'b1;
      step();
      step();
    end
    checks++;
    if (fc_c !== 8'd3 || state_c !== IDLE) begin
      errors++;
      $display("FAIL cnt_three: fallCount=%0d state=%b, want 3 00", fc_c, state_c);
    end
    fall_c = 1'b1; ack_c = 1'b1;
    for (int i = 0; i < 900; i++) step();
    checks++;
    if (fc_c !== 8'd255) begin
      errors++;
      $display("FAIL cnt_saturate: fallCount=%0d, want 255", fc_c);
    end
    rst_c = 1'b1;
    step();
    checks++;
    if (fc_c !== 8'd0 || state_c !== IDLE) begin
      errors++;
      $display("FAIL cnt_clear: fallCount=%0d state=%b, want 0 00", fc_c, state_c);
    end
    rst_c = 1'b0; fall_c = 1'b0; ack_c = 1'b0;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; fall = 1'b0; ack = 1'b0;
`ifdef FALL_EVENT_COUNTER_EN
    rst_c = 1'b1; fall_c = 1'b0; ack_c = 1'b0;
`endif
    test_reset();
    test_basic();
    test_glitch();
    test_cooldown();
    test_ack_held();
    test_reset_mid();
`ifdef FALL_EVENT_COUNTER_EN
    test_fall_counter();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
